// File: rtl/display_scan_ctrl_if.sv
// Sample handshake between a temperature producer and the display scan controller.
// No latency or storage; the consumer owns sample_ready.
// A sample transfers on any rising clk edge with sample_valid && sample_ready.
interface display_scan_ctrl_if;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_decimal;
    logic       sample_ready;

    modport master (
        output sample_valid,
        output sample_data,
        output sample_decimal,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        input  sample_decimal,
        output sample_ready
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed display scanner with a one-deep sample buffer and "Hi" splash/stale FSM.
// Accepted samples reach data/decimal at the next frame boundary (end of slot 11).
// sample_ready drops while a sample is pending; it reopens on the boundary cycle so a new sample can replace the one committing.
module display_scan_ctrl #(
    parameter int DIGIT_TICKS  = 50000,
    parameter int BLANK_TICKS  = 2,
    parameter int HI_FRAMES    = 100,
    parameter int STALE_FRAMES = 200
) (
    input  logic                clk,
    input  logic                reset,
    display_scan_ctrl_if.slave  smp,
    output logic [1:0]          select,
    output logic [7:0]          data,
    output logic                decimal,
    output logic                display_data,
    output logic [3:0]          anode_n,
    output logic                frame_done
);

    localparam int TICK_W = $clog2(DIGIT_TICKS);
    localparam int FRM_W  = $clog2(HI_FRAMES + 1);
    localparam int STL_W  = $clog2(STALE_FRAMES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_TICKS);
    localparam logic [FRM_W-1:0]  FRM_MAX   = FRM_W'(HI_FRAMES);
    localparam logic [FRM_W-1:0]  FRM_EXIT  = FRM_W'(HI_FRAMES - 1);
    localparam logic [STL_W-1:0]  STL_MAX   = STL_W'(STALE_FRAMES);

    typedef enum logic {
        SPLASH = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [TICK_W-1:0] tick, tick_nxt;
    logic [1:0]        select_nxt;
    logic              pend_full, pend_full_nxt;
    logic [7:0]        pend_data, pend_data_nxt;
    logic              pend_dec, pend_dec_nxt;
    logic [7:0]        data_nxt;
    logic              decimal_nxt;
    logic [FRM_W-1:0]  frame_cnt, frame_cnt_nxt;
    logic [STL_W-1:0]  stale_cnt, stale_cnt_nxt;
    logic [STL_W-1:0]  stale_inc;
    logic              ever, ever_nxt;
    logic              ready_q, ready_nxt;
    logic              boundary, boundary_nxt;
    logic              accept, commit;

    assign smp.sample_ready = ready_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SPLASH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        tick_nxt      = tick + TICK_W'(1);
        select_nxt    = select;
        boundary      = (select == 2'b11) && (tick == TICK_LAST);
        accept        = smp.sample_valid && ready_q;
        commit        = boundary && pend_full;

        pend_full_nxt = pend_full;
        pend_data_nxt = pend_data;
        pend_dec_nxt  = pend_dec;
        data_nxt      = data;
        decimal_nxt   = decimal;

        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        stale_cnt_nxt = stale_cnt;
        stale_inc     = stale_cnt + STL_W'(1);
        ever_nxt      = ever || commit;

        display_data  = (state == SPLASH);
        frame_done    = boundary;
        anode_n       = 4'b1111;
        if (reset && (tick >= BLANK_END)) begin
            anode_n[select] = 1'b0;
        end

        if (tick == TICK_LAST) begin
            tick_nxt   = '0;
            select_nxt = select + 2'd1;
        end
        boundary_nxt = (select_nxt == 2'b11) && (tick_nxt == TICK_LAST);

        // The committing value is the old pending; a same-cycle accept refills the buffer.
        if (commit) begin
            data_nxt      = pend_data;
            decimal_nxt   = pend_dec;
            pend_full_nxt = 1'b0;
        end
        if (accept) begin
            pend_full_nxt = 1'b1;
            pend_data_nxt = smp.sample_data;
            pend_dec_nxt  = smp.sample_decimal;
        end
        ready_nxt = !pend_full_nxt || boundary_nxt;

        if (boundary) begin
            unique case (state)
                SPLASH: begin
                    if ((frame_cnt >= FRM_EXIT) && (ever || commit)) begin
                        state_nxt     = RUN;
                        stale_cnt_nxt = '0;
                    end else if (frame_cnt != FRM_MAX) begin
                        frame_cnt_nxt = frame_cnt + FRM_W'(1);
                    end
                end
                RUN: begin
                    if (commit) begin
                        stale_cnt_nxt = '0;
                    end else if (stale_inc >= STL_MAX) begin
                        state_nxt     = SPLASH;
                        frame_cnt_nxt = '0;
                        stale_cnt_nxt = '0;
                    end else begin
                        stale_cnt_nxt = stale_inc;
                    end
                end
                default: state_nxt = SPLASH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick      <= '0;
            select    <= 2'b00;
            pend_full <= 1'b0;
            pend_data <= 8'd0;
            pend_dec  <= 1'b0;
            data      <= 8'd0;
            decimal   <= 1'b0;
            frame_cnt <= '0;
            stale_cnt <= '0;
            ever      <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            tick      <= tick_nxt;
            select    <= select_nxt;
            pend_full <= pend_full_nxt;
            pend_data <= pend_data_nxt;
            pend_dec  <= pend_dec_nxt;
            data      <= data_nxt;
            decimal   <= decimal_nxt;
            frame_cnt <= frame_cnt_nxt;
            stale_cnt <= stale_cnt_nxt;
            ever      <= ever_nxt;
            ready_q   <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scan/splash/back-pressure/stale/reset scenarios plus random samples.
// Expected commits queue up as samples are accepted; a monitor pops them at frame boundaries.
module tb_display_scan_ctrl;

    localparam int DT    = 4;
    localparam int BL    = 1;
    localparam int HI    = 2;
    localparam int ST    = 3;
    localparam int FRAME = 4 * DT;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] select;
    logic [7:0] data;
    logic       decimal;
    logic       display_data;
    logic [3:0] anode_n;
    logic       frame_done;

    display_scan_ctrl_if smp ();

    display_scan_ctrl #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BL),
        .HI_FRAMES   (HI),
        .STALE_FRAMES(ST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .smp         (smp),
        .select      (select),
        .data        (data),
        .decimal     (decimal),
        .display_data(display_data),
        .anode_n     (anode_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       dec;
        int         cyc;
    } smp_t;

    smp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n      = 0;
    bit   started = 0;

    // reference model of the committed display state
    logic [7:0] m_data;
    logic       m_dec;
    bit         m_run, m_ever;
    int         m_frames, m_stale;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    // Frame-boundary rules: commit the oldest sample accepted before this boundary cycle.
    task automatic model_boundary();
        bit   c;
        smp_t e;
        c = (q.size() > 0) && (q[0].cyc < n);
        if (c) begin
            e      = q.pop_front();
            m_data = e.d;
            m_dec  = e.dec;
            m_ever = 1;
        end
        if (!m_run) begin
            if ((m_frames + 1 >= HI) && m_ever) begin
                m_run   = 1;
                m_stale = 0;
            end else begin
                m_frames++;
            end
        end else if (c) begin
            m_stale = 0;
        end else begin
            m_stale++;
            if (m_stale >= ST) begin
                m_run    = 0;
                m_frames = 0;
            end
        end
    endtask

    initial begin : monitor
        logic       rst_s;
        logic [3:0] ea;
        int         tk, sl;
        bit         exp_rdy;
        forever begin
            @(posedge clk);
            rst_s = reset;
            #1;
            if (!rst_s) begin
                n = 0;
                q.delete();
                m_data = 8'd0; m_dec = 1'b0;
                m_run = 0; m_ever = 0; m_frames = 0; m_stale = 0;
                exp_rdy = 0;
                started = 1;
            end else if (started) begin
                if (n % FRAME == FRAME - 1) model_boundary();
                n++;
                exp_rdy = (q.size() == 0) || (n % FRAME == FRAME - 1);
            end
            if (started) begin
                tk = n % DT;
                sl = (n / DT) % 4;
                ea = 4'hF;
                if (rst_s && tk >= BL) ea[sl] = 1'b0;
                chk("select",       32'(select),       32'(sl));
                chk("anode_n",      32'(anode_n),      32'(ea));
                chk("frame_done",   32'(frame_done),   32'(rst_s && (n % FRAME == FRAME - 1)));
                chk("sample_ready", 32'(smp.sample_ready), 32'(exp_rdy));
                chk("data",         32'(data),         32'(m_data));
                chk("decimal",      32'(decimal),      32'(m_dec));
                chk("display_data", 32'(display_data), 32'(!m_run));
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (n % FRAME == p) return;
            @(negedge clk);
        end
        n_cmp++; n_fail++;
        $display("FAIL wait_phase timeout: phase %0d never reached", p);
    endtask

    // Called at a negedge; returns at a negedge with sample_valid low.
    task automatic offer(input logic [7:0] d, input logic dec);
        smp_t e;
        smp.sample_valid   = 1'b1;
        smp.sample_data    = d;
        smp.sample_decimal = dec;
        for (int w = 0; w < 4 * FRAME; w++) begin
            if (smp.sample_ready && reset) begin
                e.d = d; e.dec = dec; e.cyc = n;
                q.push_back(e);
                @(negedge clk);
                smp.sample_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        smp.sample_valid = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL accept timeout: sample %0d never accepted", d);
    endtask

    task automatic do_reset(input int k);
        reset = 1'b0;
        smp.sample_valid = 1'b0;
        idle(k);
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset              = 1'b0;
        smp.sample_valid   = 1'b0;
        smp.sample_data    = 8'd0;
        smp.sample_decimal = 1'b0;
        idle(3);
        reset = 1'b1;

        // scan only, splash holds with no commits
        idle(3 * FRAME + 2);

        // splash exit after 25.5 commits in frame 0
        do_reset(2);
        offer(8'd25, 1'b1);
        idle(2 * FRAME + 4);

        // back-to-back: second sample held until first commits
        offer(8'd30, 1'b0);
        offer(8'd31, 1'b1);
        idle(2 * FRAME);

        // accept on the boundary cycle while pending commits
        wait_phase(1);
        offer(8'd40, 1'b0);
        wait_phase(FRAME - 1);
        offer(8'd41, 1'b1);
        idle(2 * FRAME);

        // stale revert to splash, then recovery
        idle(4 * FRAME);
        offer(8'd77, 1'b1);
        idle(3 * FRAME);

        // reset during slot 10 with a pending sample
        wait_phase(0);
        offer(8'd55, 1'b0);
        wait_phase(9);
        do_reset(2);
        idle(FRAME);

        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 20));
            offer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        idle(3 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_TICKS, default 50000: clk cycles per digit slot (>=2).
REQ-002 SHALL have parameter BLANK_TICKS, default 2: anode-off cycles at the start of each slot (< DIGIT_TICKS).
REQ-003 SHALL have parameter HI_FRAMES, default 100: minimum frames of "Hi" splash after reset.
REQ-004 SHALL have parameter STALE_FRAMES, default 200: consecutive frames without a commit before reverting to splash.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low.
REQ-007 sample_valid  input  1  producer offers a temperature sample.
REQ-008 sample_data  input  8  whole-degree value, 0-255.
REQ-009 sample_decimal  input  1  half-degree flag.
REQ-010 sample_ready  output  1  pending buffer empty; sample accepted when sample_valid && sample_ready.
REQ-011 select  output  2  active digit index to the BCD/segment path (00=C, 01=tenths, 10=ones, 11=tens).
REQ-012 data  output  8  committed whole value.
REQ-013 decimal  output  1  committed half-degree flag.
REQ-014 display_data  output  1  1 = show "Hi", 0 = show temperature.
REQ-015 anode_n  output  4  active-low digit enable; bit index = select.
REQ-016 frame_done  output  1  one-cycle pulse on the last cycle of slot 11.

Function
REQ-017 Tick counter SHALL count 0..DIGIT_TICKS-1 and wrap; on wrap select SHALL advance 00->01->10->11->00.
REQ-018 anode_n SHALL be 4'b1111 while tick < BLANK_TICKS or in reset; otherwise anode_n[select]=0 and all other bits 1.
REQ-019 frame_done SHALL assert when select==11 and tick==DIGIT_TICKS-1 (the frame boundary).
REQ-020 Pending buffer: on accept, SHALL store sample_data and sample_decimal and set pend_full; sample_ready = !pend_full, registered.
REQ-021 At a frame boundary with pend_full=1, SHALL copy pending into data/decimal (commit) and clear pend_full; outputs change only at frame boundaries, so there is no tearing.
REQ-022 Accept and commit in the same cycle: the committed value SHALL be the old pending; the new sample SHALL become pending, with pend_full remaining 1.
REQ-023 The FSM SHALL have states SPLASH (display_data=1) and RUN (display_data=0); transitions occur only at frame boundaries.
REQ-024 In SPLASH, a frame counter SHALL saturate at HI_FRAMES; SPLASH->RUN when count>=HI_FRAMES-1 at the boundary and (a commit has ever occurred, or a commit occurs at this boundary).
REQ-025 In RUN, a stale counter SHALL clear on each commit and increment on each commit-less boundary; on reaching STALE_FRAMES, RUN->SPLASH with the frame counter cleared.
REQ-026 data/decimal SHALL hold their last committed values in SPLASH.
REQ-027 Counters SHALL be sized by $clog2 of their parameters; no wrap of the saturating counters.

Reset
REQ-028 While reset=0 at a clk edge: tick=0, select=00, anode_n=1111, frame_done=0, data=0, decimal=0, pend_full=0, sample_ready=0 (=1 first cycle after release), state=SPLASH, display_data=1, all frame/stale counters 0, committed-ever flag 0.
REQ-029 Reset mid-frame or mid-handshake SHALL discard pending and committed data; no accept is recorded in a reset cycle.

Verification (DIGIT_TICKS=4, BLANK_TICKS=1, HI_FRAMES=2, STALE_FRAMES=3)
REQ-030 Scan: reset release, no samples -> select steps 00,01,10,11 every 4 cycles; anode_n = 1111,1110,1110,1110 then 1111,1101...; frame_done every 16 cycles; display_data stays 1.
REQ-031 Splash exit: sample 25/decimal=1 accepted in frame 0 -> data=25, decimal=1 at the end of frame 0; display_data falls at the end of frame 1, not earlier.
REQ-032 Back-pressure: two back-to-back samples 30 then 31 -> 30 accepted, sample_ready=0, 31 held until 30 commits at the boundary; 31 commits next boundary.
REQ-033 Simultaneous: pending=40, sample 41 offered on the boundary cycle -> data=40 after boundary, pend_full=1 holding 41.
REQ-034 Stale: in RUN, no samples for 3 frames -> display_data=1 after 3rd boundary, data unchanged; a new sample then needs 2 frames to return to RUN.
REQ-035 Mid-frame reset: reset=0 while select=10 with pend_full=1 -> next cycle all REQ-028 values, data=0.
